in_fetch_sequencer: RTL and testbench

Parametrised input-fetch timing controller for the AES datapath: generates the `load` window, captures an N-word input block into an output register at a fixed phase, and issues a one-cycle `key_rst` pulse a programmable delay after reset. It generalises the fixed 4×32-bit, 16/40-cycle fetch timing with:
- parametrised word count and frame length;
- free-running or start-triggered single-shot frames;
- a `dout_valid` strobe;
- a fully registered, reset-defined `key_rst`.

---
 rtl/in_fetch_sequencer.sv | 82 ++++++++
 tb/tb_in_fetch_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/in_fetch_sequencer.sv
// in_fetch_sequencer: AES input-fetch timing (load window, N-word block capture with dout_valid, delayed key_rst pulse); in clk/rst/cont/start/hold/din, out dout/dout_valid/load/key_rst/enc/busy; IN_FETCH_HOLD_EN enables hold
module in_fetch_sequencer #(
  parameter int WORD_W      = 32,
  parameter int NWORDS      = 4,
  parameter int LOAD_CYC    = 16,
  parameter int PERIOD      = 40,
  parameter int KEY_RST_DLY = 17
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cont,
  input  logic                       start,
  input  logic                       hold,
  input  logic [NWORDS*WORD_W-1:0]   din,
  output logic [NWORDS*WORD_W-1:0]   dout,
  output logic                       dout_valid,
  output logic                       load,
  output logic                       key_rst,
  output logic [$clog2(PERIOD)-1:0]  enc,
  output logic                       busy
);
  localparam int PW = $clog2(PERIOD);
  localparam logic [PW-1:0] LC_LAST = PW'(LOAD_CYC - 1);
  localparam logic [PW-1:0] LC_CAP  = PW'(LOAD_CYC);
  localparam logic [PW-1:0] PH_LAST = PW'(PERIOD - 1);
  localparam logic [7:0]    KR      = 8'(KEY_RST_DLY);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT} state_t;
  state_t r_state, w_state;
  logic [PW-1:0] r_ph, w_ph;
  logic [NWORDS*WORD_W-1:0] r_dout;
  logic [7:0] r_cnt, w_cnt;
  logic r_pend, w_pend, r_dv, r_load, r_key, r_busy;
  logic w_hold, w_go, w_end, w_cap;
`ifdef IN_FETCH_HOLD_EN
  assign w_hold = hold && r_state != IDLE;
`else
  logic w_unused_hold;
  assign w_unused_hold = hold;
  assign w_hold = 1'b0;
`endif
  assign w_go  = cont || start || r_pend;
  assign w_end = r_state == WAIT && r_ph == PH_LAST && !w_hold;
  assign w_cap = r_state == WAIT && r_ph == LC_CAP && !w_hold;
  assign w_cnt = (r_cnt <= KR && r_cnt != 8'hFF) ? r_cnt + 8'd1 : r_cnt;
  always_comb begin
    w_state = w_hold ? r_state :
              r_state == IDLE ? (w_go ? LOAD : IDLE) :
              r_state == LOAD ? (r_ph == LC_LAST ? WAIT : LOAD) :
              w_end ? (w_go ? LOAD : IDLE) : WAIT;
    w_ph    = w_hold ? r_ph : (r_state == IDLE || w_end) ? '0 : r_ph + 1'b1;
    w_pend  = w_end ? 1'b0 : r_pend || (!cont && start && r_state != IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ph    <= '0;
      r_pend  <= 1'b0;
      r_dout  <= '0;
      r_dv    <= 1'b0;
      r_load  <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_key   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_ph    <= w_ph;
      r_pend  <= w_pend;
      if (w_cap) r_dout <= din;
      r_dv    <= w_cap;
      r_load  <= w_state == LOAD;
      r_busy  <= w_state != IDLE;
      r_cnt   <= w_cnt;
      r_key   <= w_cnt == KR && w_cnt != r_cnt;
    end
  end
  assign dout       = r_dout;
  assign dout_valid = r_dv;
  assign load       = r_load;
  assign key_rst    = r_key;
  assign enc        = r_ph;
  assign busy       = r_busy;
endmodule

// File: tb/tb_in_fetch_sequencer.sv
// tb_in_fetch_sequencer: scoreboard bench for in_fetch_sequencer (default and 8-word/4/10 builds)
module tb_in_fetch_sequencer;
  logic clk = 0, rst = 1, cont = 0, start = 0, hold = 0;
  logic [127:0] din = '0, dout;
  logic dv, load, key_rst, busy;
  logic [5:0] enc;
  logic [255:0] din8 = '0, dout8, p8;
  logic dv8, load8, key8, busy8;
  logic [3:0] enc8;
  int n_chk = 0, n_pass = 0, cyc = 0;
  typedef struct {int c; logic [127:0] d;} exp_t;
  exp_t q[$];
  localparam logic [127:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] D2 = 128'hDEADBEEF_0BADF00D_12345678_9ABCDEF0;
  localparam logic [127:0] D3 = 128'hA5A5A5A5_5A5A5A5A_F0F0F0F0_0F0F0F0F;
`ifdef IN_FETCH_HOLD_EN
  localparam int HD = 3;
`else
  localparam int HD = 0;
`endif
  always #5 clk = ~clk;
  in_fetch_sequencer u_dut (
    .clk(clk), .rst(rst), .cont(cont), .start(start), .hold(hold), .din(din),
    .dout(dout), .dout_valid(dv), .load(load), .key_rst(key_rst), .enc(enc), .busy(busy)
  );
  in_fetch_sequencer #(.NWORDS(8), .LOAD_CYC(4), .PERIOD(10)) u_dut8 (
    .clk(clk), .rst(rst), .cont(cont), .start(start), .hold(hold), .din(din8),
    .dout(dout8), .dout_valid(dv8), .load(load8), .key_rst(key8), .enc(enc8), .busy(busy8)
  );
  task automatic check(string tag, logic [255:0] got, logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h exp %0h", tag, cyc, got, exp);
  endtask
  task automatic expect_dv(int c, logic [127:0] d);
    q.push_back('{c, d});
  endtask
  task automatic sb_mon();
    exp_t e;
    if (dv) begin
      if (q.size() == 0) check("dv_spurious", dv, 0);
      else begin
        e = q.pop_front();
        check("dv_cycle", cyc, e.c);
        check("dv_data", dout, e.d);
      end
    end else if (q.size() > 0 && q[0].c <= cyc) begin
      e = q.pop_front();
      check("dv_missing", dv, 1);
    end
  endtask
  task automatic do_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    cyc = 0;
  endtask
  task automatic next();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic sample();
    @(negedge clk);
    sb_mon();
  endtask
  initial begin
    for (int i = 0; i < 8; i++) p8[i*32 +: 32] = 32'h1234ABCD ^ (32'(i) * 32'h11111111);
    // free-running frames, plus the 8-word build alongside
    cont = 1;
    din = D1;
    din8 = p8;
    do_reset();
    expect_dv(18, D1);
    for (int c = 0; c <= 60; c++) begin
      if (c > 0) next();
      if (c == 8) din8 = ~p8;
      if (c == 30) begin
        din = D2;
        expect_dv(58, D2);
      end
      sample();
      check("load", load, (c >= 1 && c <= 16) || (c >= 41 && c <= 56));
      check("key_rst", key_rst, c == 17);
      check("busy", busy, c >= 1);
      check("enc", enc, c == 0 ? 0 : (c - 1) % 40);
      check("load8", load8, c % 10 >= 1 && c % 10 <= 4);
      check("dv8", dv8, c % 10 == 6);
      if (c == 0) check("dout_rst", dout, 0);
      if (c == 6) check("dout8_a", dout8, p8);
      if (c == 16) check("dout8_b", dout8, ~p8);
      if (c == 40) check("dout_stable", dout, D1);
    end
    check("sb_empty1", q.size(), 0);
    // single-shot with pending start (third start absorbed)
    cont = 0;
    din = D3;
    do_reset();
    for (int c = 0; c <= 90; c++) begin
      if (c > 0) next();
      start = c == 5 || c == 20 || c == 30;
      if (c == 5) expect_dv(23, D3);
      if (c == 20) expect_dv(63, D3);
      sample();
      check("ss_load", load, (c >= 6 && c <= 21) || (c >= 46 && c <= 61));
      check("ss_busy", busy, c >= 6 && c <= 85);
      check("ss_enc", enc, (c >= 6 && c <= 85) ? (c - 6) % 40 : 0);
    end
    start = 0;
    check("sb_empty2", q.size(), 0);
    // cont dropped mid-frame
    cont = 1;
    din = D1;
    do_reset();
    expect_dv(18, D1);
    for (int c = 0; c <= 50; c++) begin
      if (c > 0) next();
      if (c == 30) cont = 0;
      sample();
      check("cd_busy", busy, c >= 1 && c <= 40);
      check("cd_load", load, c >= 1 && c <= 16);
    end
    check("sb_empty3", q.size(), 0);
    // reset mid-frame
    cont = 1;
    din = D2;
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) next();
      if (c == 10) rst = 1;
      sample();
      check("rm_load_pre", load, c >= 1);
    end
    @(posedge clk);
    #1;
    rst = 0;
    cyc = 0;
    expect_dv(18, D2);
    for (int c = 0; c <= 20; c++) begin
      if (c > 0) next();
      sample();
      if (c == 0) begin
        check("rm_busy0", busy, 0);
        check("rm_enc0", enc, 0);
        check("rm_dv0", dv, 0);
        check("rm_dout0", dout, 0);
      end
      check("rm_load", load, c >= 1 && c <= 16);
      check("rm_key_rst", key_rst, c == 17);
    end
    check("sb_empty4", q.size(), 0);
    // hold in cycles 17..19 (frozen only when the hold feature is built in)
    cont = 1;
    din = D3;
    do_reset();
    expect_dv(18 + HD, D3);
    for (int c = 0; c <= 46; c++) begin
      if (c > 0) next();
      hold = c >= 17 && c <= 19;
      sample();
      check("h_load", load, (c >= 1 && c <= 16) || (c >= 41 + HD));
      check("h_enc", enc, c == 0 ? 0 : c < 17 ? c - 1 : c < 17 + HD ? 16 : (c - 1 - HD) % 40);
      check("h_key_rst", key_rst, c == 17);
    end
    hold = 0;
    cont = 0;
    check("sb_empty5", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
